// File: rtl/lcd_timing_ctrl_if.sv
// Pixel-source handshake between the LCD timing controller (master) and
// whatever produces pixels (pattern generator, frame buffer reader).
interface lcd_timing_ctrl_if #(
    parameter int CW = 11
);
    logic          pixel_req;
    logic [CW-1:0] pixel_xpos;
    logic [CW-1:0] pixel_ypos;
    logic          frame_start;
    logic          line_start;
    logic [23:0]   pixel_data;

    modport master (
        output pixel_req,
        output pixel_xpos,
        output pixel_ypos,
        output frame_start,
        output line_start,
        input  pixel_data
    );

    modport slave (
        input  pixel_req,
        input  pixel_xpos,
        input  pixel_ypos,
        input  frame_start,
        input  line_start,
        output pixel_data
    );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// Parametrised RGB888 LCD timing controller: scan counters, pixel requests,
// and sync/DE/RGB outputs delayed by REQ_LEAD to match the pixel source latency.
module lcd_timing_ctrl #(
    parameter int CW       = 11,
    parameter int H_SYNC   = 46,
    parameter int H_BACK   = 0,
    parameter int H_DISP   = 800,
    parameter int H_FRONT  = 210,
    parameter int V_SYNC   = 23,
    parameter int V_BACK   = 0,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 22,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter bit DE_MODE  = 1'b1,
    parameter int REQ_LEAD = 1
) (
    input  logic                lcd_clk,
    input  logic                sys_rst_n,
    input  logic                enable,
    lcd_timing_ctrl_if.master   pix,
    output logic                lcd_hs,
    output logic                lcd_vs,
    output logic                lcd_de,
    output logic [23:0]         lcd_rgb,
    output logic                lcd_bl,
    output logic                lcd_rst,
    output logic                lcd_pclk
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_LO   = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT_HI   = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_ACT_LO   = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT_HI   = CW'(V_SYNC + V_BACK + V_DISP);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt_h;
    logic [CW-1:0] cnt_v;
    logic          running;
    logic          h_wrap;
    logic          v_wrap;

    assign running = (state == ST_RUN);
    assign h_wrap  = (cnt_h == H_LAST);
    assign v_wrap  = (cnt_v == V_LAST);

    // enable is only honoured at the frame wrap, so a frame is never cut short
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (state == ST_IDLE) begin
            cnt_h <= '0;
            cnt_v <= '0;
            if (enable) begin
                state <= ST_RUN;
            end
        end else if (h_wrap) begin
            cnt_h <= '0;
            if (v_wrap) begin
                cnt_v <= '0;
                if (!enable) begin
                    state <= ST_IDLE;
                end
            end else begin
                cnt_v <= cnt_v + CW'(1);
            end
        end else begin
            cnt_h <= cnt_h + CW'(1);
        end
    end

    logic h_active;
    logic v_active;
    logic de_raw;
    logic hs_raw;
    logic vs_raw;

    assign h_active = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI);
    assign v_active = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
    assign de_raw   = running && h_active && v_active;
    assign hs_raw   = running && (cnt_h < H_SYNC_END);
    assign vs_raw   = running && (cnt_v < V_SYNC_END);

    assign pix.pixel_req   = de_raw;
    assign pix.pixel_xpos  = de_raw ? (cnt_h - H_ACT_LO) : '0;
    assign pix.pixel_ypos  = de_raw ? (cnt_v - V_ACT_LO) : '0;
    assign pix.frame_start = running && (cnt_h == '0) && (cnt_v == '0);
    assign pix.line_start  = running && (cnt_h == '0);

    // tap[0] is the raw decode, tap[k] the value k cycles later
    logic [REQ_LEAD-1:0] hs_pipe;
    logic [REQ_LEAD-1:0] vs_pipe;
    logic [REQ_LEAD-1:0] de_pipe;
    logic [REQ_LEAD:0]   hs_tap;
    logic [REQ_LEAD:0]   vs_tap;
    logic [REQ_LEAD:0]   de_tap;

    assign hs_tap = {hs_pipe, hs_raw};
    assign vs_tap = {vs_pipe, vs_raw};
    assign de_tap = {de_pipe, de_raw};

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
            de_pipe <= '0;
        end else begin
            hs_pipe <= hs_tap[REQ_LEAD-1:0];
            vs_pipe <= vs_tap[REQ_LEAD-1:0];
            de_pipe <= de_tap[REQ_LEAD-1:0];
        end
    end

    // pixel_data is captured on the same edge that moves its DE into the last stage
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcd_rgb <= '0;
        end else begin
            lcd_rgb <= de_tap[REQ_LEAD-1] ? pix.pixel_data : 24'h000000;
        end
    end

    assign lcd_de = de_tap[REQ_LEAD];
    assign lcd_hs = DE_MODE ? 1'b1 : (hs_tap[REQ_LEAD] ? HS_POL : ~HS_POL);
    assign lcd_vs = DE_MODE ? 1'b1 : (vs_tap[REQ_LEAD] ? VS_POL : ~VS_POL);

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcd_bl  <= 1'b0;
            lcd_rst <= 1'b0;
        end else begin
            lcd_bl  <= 1'b1;
            lcd_rst <= 1'b1;
        end
    end

    assign lcd_pclk = lcd_clk;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Randomised bench for lcd_timing_ctrl: two instances (REQ_LEAD=1 sync mode,
// REQ_LEAD=3 DE-only) on a 15x8 geometry against a frame-phase reference model.
module tb_lcd_timing_ctrl;

    localparam int HSY = 2, HBK = 3, HDI = 8, HFR = 2;
    localparam int VSY = 1, VBK = 2, VDI = 4, VFR = 1;
    localparam int HT = HSY + HBK + HDI + HFR;
    localparam int VT = VSY + VBK + VDI + VFR;

    logic clk;
    logic rstN;
    logic en;

    lcd_timing_ctrl_if #(.CW(11)) ifA ();
    lcd_timing_ctrl_if #(.CW(11)) ifB ();

    logic        hsA, vsA, deA, blA, rstA, pclkA;
    logic [23:0] rgbA;
    logic        hsB, vsB, deB, blB, rstB, pclkB;
    logic [23:0] rgbB;

    lcd_timing_ctrl #(
        .CW(11), .H_SYNC(HSY), .H_BACK(HBK), .H_DISP(HDI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_DISP(VDI), .V_FRONT(VFR),
        .HS_POL(1'b1), .VS_POL(1'b0), .DE_MODE(1'b0), .REQ_LEAD(1)
    ) dutA (
        .lcd_clk(clk), .sys_rst_n(rstN), .enable(en), .pix(ifA),
        .lcd_hs(hsA), .lcd_vs(vsA), .lcd_de(deA), .lcd_rgb(rgbA),
        .lcd_bl(blA), .lcd_rst(rstA), .lcd_pclk(pclkA)
    );

    lcd_timing_ctrl #(
        .CW(11), .H_SYNC(HSY), .H_BACK(HBK), .H_DISP(HDI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_DISP(VDI), .V_FRONT(VFR),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_MODE(1'b1), .REQ_LEAD(3)
    ) dutB (
        .lcd_clk(clk), .sys_rst_n(rstN), .enable(en), .pix(ifB),
        .lcd_hs(hsB), .lcd_vs(vsB), .lcd_de(deB), .lcd_rgb(rgbB),
        .lcd_bl(blB), .lcd_rst(rstB), .lcd_pclk(pclkB)
    );

    // Source A answers combinationally; source B is a two-stage pipeline
    assign ifA.pixel_data = 24'(ifA.pixel_xpos) + (24'(ifA.pixel_ypos) << 4);

    logic [23:0] srcB1, srcB2;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            srcB1 <= '0;
            srcB2 <= '0;
        end else begin
            srcB1 <= 24'(ifB.pixel_xpos) + (24'(ifB.pixel_ypos) << 8);
            srcB2 <= srcB1;
        end
    end
    assign ifB.pixel_data = srcB2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit          hs;
        bit          vs;
        bit          de;
        logic [23:0] pixA;
        logic [23:0] pixB;
    } raw_t;

    raw_t        hist [0:4];
    bit          running;
    int          phase;
    int          edges;
    logic        expReq, expFs, expLs;
    logic [10:0] expX, expY;

    int checks = 0;
    int errors = 0;
    int cycleNum = 0;
    int deCountA = 0;
    int fsCountA = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycleNum, obs, exp);
        end
    endtask

    // Expected values for the current cycle from the frame phase alone
    task automatic computeCurrent(input bit doShift);
        int   h, v;
        bit   req;
        raw_t cur;
        h   = running ? phase % HT : 0;
        v   = running ? phase / HT : 0;
        req = running && h >= HSY + HBK && h < HSY + HBK + HDI
                      && v >= VSY + VBK && v < VSY + VBK + VDI;
        expReq = req;
        expX   = req ? 11'(h - HSY - HBK) : 11'd0;
        expY   = req ? 11'(v - VSY - VBK) : 11'd0;
        expFs  = running && phase == 0;
        expLs  = running && h == 0;
        cur.hs   = running && h < HSY;
        cur.vs   = running && v < VSY;
        cur.de   = req;
        cur.pixA = req ? 24'((h - HSY - HBK) + 16 * (v - VSY - VBK)) : 24'd0;
        cur.pixB = req ? 24'((h - HSY - HBK) + 256 * (v - VSY - VBK)) : 24'd0;
        if (doShift) begin
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        end
        hist[0] = cur;
    endtask

    task automatic modelEdge();
        edges++;
        if (!running) begin
            if (en) begin
                running = 1'b1;
                phase   = 0;
            end
        end else if (phase == HT * VT - 1) begin
            phase   = 0;
            running = en;
        end else begin
            phase++;
        end
        computeCurrent(1'b1);
    endtask

    task automatic modelReset();
        running = 1'b0;
        phase   = 0;
        edges   = 0;
        for (int i = 0; i < 5; i++) hist[i] = '0;
        computeCurrent(1'b0);
    endtask

    task automatic checkCycle();
        logic e;
        e = (edges > 0);
        checkOutput("srcA", 64'({ifA.pixel_req, ifA.pixel_xpos, ifA.pixel_ypos, ifA.frame_start, ifA.line_start}),
                    64'({expReq, expX, expY, expFs, expLs}));
        checkOutput("srcB", 64'({ifB.pixel_req, ifB.pixel_xpos, ifB.pixel_ypos, ifB.frame_start, ifB.line_start}),
                    64'({expReq, expX, expY, expFs, expLs}));
        checkOutput("panelA", 64'({hsA, vsA, deA, rgbA}),
                    64'({hist[1].hs, ~hist[1].vs, hist[1].de, hist[1].pixA}));
        checkOutput("panelB", 64'({hsB, vsB, deB, rgbB}),
                    64'({1'b1, 1'b1, hist[3].de, hist[3].pixB}));
        checkOutput("misc", 64'({blA, rstA, pclkA, blB, rstB, pclkB}),
                    64'({e, e, clk, e, e, clk}));
        deCountA += int'(deA);
        fsCountA += int'(ifA.frame_start);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle();
        @(negedge clk);
        cycleNum++;
    endtask

    // Called between edges: assert reset, check immediate response, release
    task automatic resetPulse();
        rstN = 1'b0;
        #1;
        modelReset();
        checkCycle();
        #1;
        rstN = 1'b1;
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 99) < 3) en = ~en;
        if ($urandom_range(0, 999) < 4) resetPulse();
    endtask

    initial begin
        int  prevFs;
        bit  found;
        rstN = 1'b0;
        en   = 1'b0;
        modelReset();
        #1;
        checkCycle();
        #1;
        rstN = 1'b1;
        en   = 1'b1;

        stepCycle();
        checkOutput("first_fs", 64'(ifA.frame_start), 64'd1);
        prevFs = cycleNum - 1;
        for (int i = 0; i < 250; i++) begin
            stepCycle();
            if (ifA.frame_start) begin
                checkOutput("fs_period", 64'(cycleNum - 1 - prevFs), 64'(HT * VT));
                prevFs = cycleNum - 1;
            end
        end

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            stepCycle();
            found = running && (phase / HT == 2);
        end
        checkOutput("wait_v2", 64'(found), 64'd1);
        en = 1'b0;
        deCountA = 0;
        fsCountA = 0;
        for (int i = 0; i < 200; i++) stepCycle();
        checkOutput("drop_de_count", 64'(deCountA), 64'(HDI * VDI));
        checkOutput("drop_fs_count", 64'(fsCountA), 64'd0);
        en = 1'b1;
        stepCycle();
        checkOutput("restart_fs", 64'(ifA.frame_start), 64'd1);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            stepCycle();
            found = expReq;
        end
        checkOutput("wait_active", 64'(found), 64'd1);
        resetPulse();
        stepCycle();
        checkOutput("post_rst_fs", 64'(ifA.frame_start), 64'd1);

        for (int i = 0; i < 2500; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
